// File: rtl/spi_master_16bit.sv
// SPI mode-3 master: one 16-bit word per SS_n assertion, MSB first, with the response
// word captured from MISO in the same frame. SCLK, SS_n and MOSI are all registered.
module spi_master_16bit #(
    parameter int unsigned CLK_DIV = 6,  // clk cycles per SCLK half-period, >= 2
    parameter int unsigned SS_LEAD = 2,  // SS_n low before first SCLK falling edge, >= 1
    parameter int unsigned SS_LAG  = 2,  // after last SCLK rising edge before SS_n rises, >= 1
    parameter int unsigned SS_GAP  = 4   // SS_n high after a frame before ready, >= 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] tx_data,
    input  logic        abort,
    output logic        ready,
    output logic        busy,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int unsigned HW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TMX0 = (SS_LEAD > SS_LAG) ? SS_LEAD : SS_LAG;
    localparam int unsigned TMAX = (TMX0 > SS_GAP) ? TMX0 : SS_GAP;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {StIdle, StLead, StShift, StLag, StGap} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;        // SCLK half-period counter
    logic [TW-1:0] tcnt_q, tcnt_d;        // LEAD/LAG/GAP duration counter
    logic [4:0]    bit_cnt_q, bit_cnt_d;  // SCLK rising edges seen this frame
    logic [15:0]   shift_tx_q, shift_tx_d;
    logic [15:0]   shift_rx_q, shift_rx_d;
    logic [15:0]   rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          sclk_q, sclk_d;
    logic          ss_n_q, ss_n_d;
    logic          mosi_q, mosi_d;
    logic          miso_q;

    // State and datapath registers; async reset returns the bus to idle immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            hcnt_q     <= '0;
            tcnt_q     <= '0;
            bit_cnt_q  <= '0;
            shift_tx_q <= '0;
            shift_rx_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b1;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            tcnt_q     <= tcnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_tx_q <= shift_tx_d;
            shift_rx_q <= shift_rx_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            miso_q     <= MISO;
        end
    end

    // Next-state logic for the frame sequencer and the SPI pins
    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        tcnt_d     = tcnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_tx_d = shift_tx_q;
        shift_rx_d = shift_rx_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        ss_n_d     = ss_n_q;
        mosi_d     = mosi_q;

        case (state_q)
            StIdle: begin
                // abort is ignored here, so start wins when both are high
                if (start) begin
                    shift_tx_d = tx_data;
                    shift_rx_d = '0;
                    bit_cnt_d  = '0;
                    tcnt_d     = '0;
                    ss_n_d     = 1'b0;
                    state_d    = StLead;
                end
            end
            StLead: begin
                if (abort) begin
                    state_d = StGap;
                end else if (tcnt_q == TW'(SS_LEAD - 1)) begin
                    // First falling edge carries the MSB out
                    sclk_d     = 1'b0;
                    mosi_d     = shift_tx_q[15];
                    shift_tx_d = {shift_tx_q[14:0], 1'b0};
                    hcnt_d     = '0;
                    state_d    = StShift;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StShift: begin
                if (abort) begin
                    state_d = StGap;
                end else if (hcnt_q == HW'(CLK_DIV - 1)) begin
                    hcnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d     = 1'b1;
                        shift_rx_d = {shift_rx_q[14:0], miso_q};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                    end else if (bit_cnt_q == 5'd16) begin
                        tcnt_d  = '0;
                        state_d = StLag;
                    end else begin
                        sclk_d     = 1'b0;
                        mosi_d     = shift_tx_q[15];
                        shift_tx_d = {shift_tx_q[14:0], 1'b0};
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            StLag: begin
                if (abort) begin
                    state_d = StGap;
                end else if (tcnt_q == TW'(SS_LAG - 1)) begin
                    rx_data_d  = shift_rx_q;
                    rx_valid_d = 1'b1;
                    state_d    = StGap;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StGap: begin
                if (tcnt_q == TW'(SS_GAP - 1)) begin
                    state_d = StIdle;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Every entry into GAP (normal end or abort) parks the bus
        if (state_q != StGap && state_d == StGap) begin
            sclk_d = 1'b1;
            ss_n_d = 1'b1;
            mosi_d = 1'b0;
            tcnt_d = '0;
        end
    end

    assign ready    = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign SS_n     = ss_n_q;
    assign SCLK     = sclk_q;
    assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_16bit.sv
// Directed bench for spi_master_16bit with a mode-3 slave model and optional MISO loopback.
module tb_spi_master_16bit;

    localparam int CLK_DIV = 6;
    localparam int SS_LEAD = 2;
    localparam int SS_LAG  = 2;
    localparam int SS_GAP  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] tx_data = 16'h0;
    logic        abort = 1'b0;
    logic        ready, busy, rx_valid, SS_n, SCLK, MOSI, MISO;
    logic [15:0] rx_data;

    int checks = 0;
    int failures = 0;

    spi_master_16bit #(
        .CLK_DIV(CLK_DIV),
        .SS_LEAD(SS_LEAD),
        .SS_LAG (SS_LAG),
        .SS_GAP (SS_GAP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .tx_data (tx_data),
        .abort   (abort),
        .ready   (ready),
        .busy    (busy),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    always #10 clk = ~clk;

    // Slave model: counts SCLK rising edges within SS_n low, logs MOSI, drives response bits
    int          rises = 0;
    int          falls_total = 0;
    int          rxv_total = 0;
    logic        sclk_prev = 1'b1;
    logic [15:0] mosi_log = 16'h0;
    logic [15:0] slave_resp = 16'h0;
    logic        loopback = 1'b0;

    always @(posedge clk) begin
        sclk_prev <= SCLK;
        if (rx_valid) rxv_total <= rxv_total + 1;
        if (!SCLK && sclk_prev) falls_total <= falls_total + 1;
        if (SS_n) rises <= 0;
        else if (SCLK && !sclk_prev) begin
            rises    <= rises + 1;
            mosi_log <= {mosi_log[14:0], MOSI};
        end
    end

    assign MISO = loopback ? MOSI : ((rises < 16) ? slave_resp[4'(15 - rises)] : 1'b0);

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++; failures++;
            $display("FAIL wait_ready timeout ready=%b required=1", ready);
        end
    endtask

    task automatic wait_rises(input int target);
        int n = 0;
        while (rises < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (rises < target) begin
            checks++; failures++;
            $display("FAIL wait_rises timeout rises=%0d required=%0d", rises, target);
        end
    endtask

    // Launches one frame; lat = cycles from the accepting cycle to the rx_valid cycle
    task automatic run_frame(input logic [15:0] tx, output int lat);
        wait_ready();
        start = 1'b1;
        tx_data = tx;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!rx_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (!rx_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (SS_n !== 1'b1) begin failures++; $display("FAIL reset_ss_n got=%b exp=1", SS_n); end
        checks++; if (SCLK !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%b exp=1", SCLK); end
        checks++; if (MOSI !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", MOSI); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rx_data !== 16'h0) begin failures++; $display("FAIL reset_rx_data got=%h exp=0000", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int lat, f0, v0;
        slave_resp = 16'hA5C3;
        loopback = 1'b0;
        f0 = falls_total;
        v0 = rxv_total;
        run_frame(16'h0001, lat);
        // 1 + SS_LEAD + 32*CLK_DIV + SS_LAG = 1 + 2 + 192 + 2
        checks++; if (lat != 197) begin failures++; $display("FAIL frame_latency got=%0d exp=197", lat); end
        checks++; if (rx_data !== 16'hA5C3) begin failures++; $display("FAIL frame_rx_data got=%h exp=a5c3", rx_data); end
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL frame_rx_valid_width got=%b exp=0", rx_valid); end
        repeat (10) @(negedge clk);
        checks++; if (falls_total - f0 != 16) begin failures++; $display("FAIL frame_sclk_falls got=%0d exp=16", falls_total - f0); end
        checks++; if (rxv_total - v0 != 1) begin failures++; $display("FAIL frame_rx_valid_count got=%0d exp=1", rxv_total - v0); end
        checks++; if (mosi_log !== 16'h0001) begin failures++; $display("FAIL frame_mosi_bits got=%h exp=0001", mosi_log); end
    endtask

    task automatic test_reset_mid_shift();
        int lat, f0;
        slave_resp = 16'hA5C3;
        wait_ready();
        start = 1'b1;
        tx_data = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        wait_rises(5);
        // Move into the SCLK-low half so the reset visibly drives SCLK high
        repeat (CLK_DIV + 2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (SS_n !== 1'b1) begin failures++; $display("FAIL midrst_ss_n got=%b exp=1", SS_n); end
        checks++; if (SCLK !== 1'b1) begin failures++; $display("FAIL midrst_sclk got=%b exp=1", SCLK); end
        checks++; if (MOSI !== 1'b0) begin failures++; $display("FAIL midrst_mosi got=%b exp=0", MOSI); end
        checks++; if (rx_data !== 16'h0) begin failures++; $display("FAIL midrst_rx_data got=%h exp=0000", rx_data); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        f0 = falls_total;
        run_frame(16'h00F0, lat);
        checks++; if (lat != 197) begin failures++; $display("FAIL postrst_latency got=%0d exp=197", lat); end
        checks++; if (rx_data !== 16'hA5C3) begin failures++; $display("FAIL postrst_rx_data got=%h exp=a5c3", rx_data); end
        repeat (10) @(negedge clk);
        checks++; if (falls_total - f0 != 16) begin failures++; $display("FAIL postrst_sclk_falls got=%0d exp=16", falls_total - f0); end
        checks++; if (mosi_log !== 16'h00F0) begin failures++; $display("FAIL postrst_mosi_bits got=%h exp=00f0", mosi_log); end
    endtask

    task automatic test_back_to_back();
        int cyc = 0, rv1 = -1, acc2 = -1, rv2 = -1, gap_hi = 0, v0;
        logic seen_idle = 1'b0;
        logic [15:0] r1 = 16'h0, r2 = 16'h0;
        slave_resp = 16'h1234;
        wait_ready();
        v0 = rxv_total;
        start = 1'b1;
        tx_data = 16'h0003;
        while (rv2 < 0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (rx_valid) begin
                if (rv1 < 0) begin rv1 = cyc; r1 = rx_data; end
                else if (acc2 >= 0) begin rv2 = cyc; r2 = rx_data; end
            end
            if (rv1 >= 0 && acc2 < 0) begin
                if (!busy) seen_idle = 1'b1;
                else if (seen_idle) begin acc2 = cyc; start = 1'b0; end
                else if (SS_n) gap_hi++;
            end
        end
        start = 1'b0;
        checks++; if (rv1 != 197) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=197", rv1); end
        checks++; if (acc2 - rv1 != SS_GAP + 1) begin failures++; $display("FAIL b2b_accept_gap got=%0d exp=%0d", acc2 - rv1, SS_GAP + 1); end
        checks++; if (gap_hi != SS_GAP) begin failures++; $display("FAIL b2b_gap_ss_high got=%0d exp=%0d", gap_hi, SS_GAP); end
        checks++; if (rv2 - rv1 != 201) begin failures++; $display("FAIL b2b_second_rx_valid got=%0d exp=201", rv2 - rv1); end
        checks++; if (r1 !== 16'h1234) begin failures++; $display("FAIL b2b_rx1 got=%h exp=1234", r1); end
        checks++; if (r2 !== 16'h1234) begin failures++; $display("FAIL b2b_rx2 got=%h exp=1234", r2); end
        repeat (10) @(negedge clk);
        checks++; if (rxv_total - v0 != 2) begin failures++; $display("FAIL b2b_rx_valid_count got=%0d exp=2", rxv_total - v0); end
    endtask

    task automatic test_ignored_start();
        int cyc = 1, v0;
        logic [15:0] got = 16'h0;
        slave_resp = 16'h0F0F;
        wait_ready();
        v0 = rxv_total;
        start = 1'b1;
        tx_data = 16'h1357;
        @(negedge clk);
        start = 1'b0;
        while (!rx_valid && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 50) begin
                start = 1'b1;
                tx_data = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        got = rx_data;
        repeat (250) @(negedge clk);
        checks++; if (got !== 16'h0F0F) begin failures++; $display("FAIL ignore_rx_data got=%h exp=0f0f", got); end
        checks++; if (mosi_log !== 16'h1357) begin failures++; $display("FAIL ignore_mosi_bits got=%h exp=1357", mosi_log); end
        checks++; if (rxv_total - v0 != 1) begin failures++; $display("FAIL ignore_rx_valid_count got=%0d exp=1", rxv_total - v0); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL ignore_ready got=%b exp=1", ready); end
    endtask

    task automatic test_abort();
        int n, v0;
        wait_ready();
        v0 = rxv_total;
        start = 1'b1;
        tx_data = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        wait_rises(8);
        repeat (CLK_DIV + 2) @(negedge clk);
        checks++; if (SCLK !== 1'b0) begin failures++; $display("FAIL abort_pre_sclk got=%b exp=0", SCLK); end
        checks++; if (MOSI !== 1'b1) begin failures++; $display("FAIL abort_pre_mosi got=%b exp=1", MOSI); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n = 1;
        checks++; if (SS_n !== 1'b1) begin failures++; $display("FAIL abort_ss_n got=%b exp=1", SS_n); end
        checks++; if (SCLK !== 1'b1) begin failures++; $display("FAIL abort_sclk got=%b exp=1", SCLK); end
        checks++; if (MOSI !== 1'b0) begin failures++; $display("FAIL abort_mosi got=%b exp=0", MOSI); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy got=%b exp=1", busy); end
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != SS_GAP + 1) begin failures++; $display("FAIL abort_ready_delay got=%0d exp=%0d", n, SS_GAP + 1); end
        repeat (10) @(negedge clk);
        checks++; if (rxv_total - v0 != 0) begin failures++; $display("FAIL abort_rx_valid_count got=%0d exp=0", rxv_total - v0); end
        checks++; if (rx_data !== 16'h0F0F) begin failures++; $display("FAIL abort_rx_data got=%h exp=0f0f", rx_data); end
    endtask

    task automatic test_loopback();
        int lat;
        loopback = 1'b1;
        run_frame(16'h8001, lat);
        checks++; if (lat != 197) begin failures++; $display("FAIL loop1_latency got=%0d exp=197", lat); end
        checks++; if (rx_data !== 16'h8001) begin failures++; $display("FAIL loop1_rx_data got=%h exp=8001", rx_data); end
        checks++; if (mosi_log !== 16'h8001) begin failures++; $display("FAIL loop1_mosi_bits got=%h exp=8001", mosi_log); end
        run_frame(16'h7FFE, lat);
        checks++; if (rx_data !== 16'h7FFE) begin failures++; $display("FAIL loop2_rx_data got=%h exp=7ffe", rx_data); end
        checks++; if (mosi_log !== 16'h7FFE) begin failures++; $display("FAIL loop2_mosi_bits got=%h exp=7ffe", mosi_log); end
        loopback = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_reset_mid_shift();
        test_back_to_back();
        test_ignored_start();
        test_abort();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
